// File: rtl/shift_frame_controller.sv
// -----------------------------------------------------------------------------
// shift_frame_controller
//
// Upstream sequencing stage for a WIDTH-bit left-shift register. Parallel words
// arrive over a valid/ready handshake into a small FIFO. For each word the block
// issues one load cycle and then WIDTH shift cycles to the register, and frames
// the register's MSB as an MSB-first serial stream. GAP idle cycles separate
// consecutive frames. All frame timing lives here; the shift register is a pure
// datapath element.
//
// Handshake: a word transfers on any rising edge where in_valid && in_ready.
// in_ready is simply "FIFO not full" and does not depend on in_valid.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready upstream handshake, in_data is the word
//   sr_load, sr_shift, sr_data_in  drive the shift register
//   sr_msb            shift register data_out[WIDTH-1]
//   ser_valid/ser_bit serial frame output, MSB first
//   ser_first/ser_last frame delimiters (bit 0 / bit WIDTH-1)
//   busy              FSM active or words still buffered
//   word_count        frames completed, modulo 256
//   state_dbg         current FSM state (IDLE=0, LOAD=1, SHIFT=2, GAP=3)
// -----------------------------------------------------------------------------
module shift_frame_controller #(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int GAP        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sr_load,
  output logic             sr_shift,
  output logic [WIDTH-1:0] sr_data_in,
  input  logic             sr_msb,
  output logic             ser_valid,
  output logic             ser_bit,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy,
  output logic [7:0]       word_count,
  output logic [1:0]       state_dbg
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = 4;

  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  // The gap counter counts down to zero, so it is loaded with GAP-1.
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [7:0]        word_count_q, word_count_d;

  logic [WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              push, pop, fifo_empty;

  // ---------------------------------------------------------------------------
  // Input FIFO. Pointers wrap naturally because the depth is a power of two.
  // ---------------------------------------------------------------------------
  assign fifo_empty = (count_q == '0);
  assign in_ready   = (count_q != FULL_CNT);
  assign push       = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bitcnt_q     <= '0;
      gap_q        <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      gap_q        <= gap_d;
      word_count_q <= word_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    gap_d        = gap_q;
    word_count_d = word_count_q;
    pop          = 1'b0;
    sr_load      = 1'b0;
    sr_shift     = 1'b0;
    sr_data_in   = '0;
    ser_valid    = 1'b0;
    ser_bit      = 1'b0;
    ser_first    = 1'b0;
    ser_last     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) state_d = S_LOAD;
      end

      S_LOAD: begin
        sr_load    = 1'b1;
        sr_data_in = mem_q[rd_ptr_q];
        pop        = 1'b1;
        bitcnt_d   = '0;
        state_d    = S_SHIFT;
      end

      S_SHIFT: begin
        sr_shift  = 1'b1;
        ser_valid = 1'b1;
        // Register output passes straight through; it already reflects the
        // load/shift of the previous edge.
        ser_bit   = sr_msb;
        ser_first = (bitcnt_q == '0);
        ser_last  = (bitcnt_q == LAST_BIT);
        bitcnt_d  = bitcnt_q + BW'(1);
        if (bitcnt_q == LAST_BIT) begin
          word_count_d = word_count_q + 8'd1;
          if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end else if (!fifo_empty) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_GAP: begin
        if (gap_q == '0) begin
          state_d = fifo_empty ? S_IDLE : S_LOAD;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE) || !fifo_empty;
  assign word_count = word_count_q;
  assign state_dbg  = state_q;

endmodule

// File: doc/shift_frame_controller.md
# shift_frame_controller

Upstream sequencing stage for the 4-bit left-shift register. It accepts parallel words over a valid/ready handshake and buffers them in a small FIFO. For each word it drives the register's load, shift and parallel data inputs, then presents the register's MSB as a framed, MSB-first serial stream. It owns all frame timing, so the shift register stays a pure datapath element.

## Interface
- WIDTH, 4: word width; must equal the shift register width.
- FIFO_DEPTH, 2: input buffer entries; power of two, ≥ 2.
- GAP, 1: idle cycles between frames; 0 to 15 allowed.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  FIFO not full; a word transfers when in_valid && in_ready.
- in_data  in  WIDTH  upstream word.
- sr_load  out  1  to shift register load.
- sr_shift  out  1  to shift register shift.
- sr_data_in  out  WIDTH  to shift register data_in.
- sr_msb  in  1  shift register data_out[WIDTH-1].
- ser_valid  out  1  ser_bit is a frame bit this cycle.
- ser_bit  out  1  serial bit, MSB first.
- ser_first  out  1  high with bit 0 of a frame.
- ser_last  out  1  high with bit WIDTH-1 of a frame.
- busy  out  1  FSM not in IDLE, or FIFO not empty.
- word_count  out  8  frames completed, modulo 256.

## Operation
- FIFO
  - Push on in_valid && in_ready. Pop only in the LOAD state.
  - in_ready = !full. No push is possible when full, so a push and pop in the same cycle only occur when not full; the count is then unchanged.
- FSM states: IDLE, LOAD, SHIFT, GAP.
- IDLE
  - FIFO non-empty -> LOAD.
- LOAD (exactly 1 cycle)
  - sr_load=1, sr_data_in=FIFO head, sr_shift=0.
  - Pop the FIFO, clear the bit counter, -> SHIFT.
- SHIFT (exactly WIDTH cycles)
  - ser_valid=1, ser_bit=sr_msb, sr_shift=1 every cycle.
  - ser_first when bitcnt==0; ser_last when bitcnt==WIDTH-1.
  - On the last bit: word_count+1 (wraps 255->0).
    - GAP>0 -> GAP state with gap counter loaded.
    - GAP==0 and FIFO non-empty -> LOAD.
    - Otherwise -> IDLE.
- GAP (exactly GAP cycles)
  - All sr_* and ser_* outputs 0.
  - On expiry: FIFO non-empty -> LOAD, else -> IDLE.
- Outside LOAD: sr_load=0 and sr_data_in=0.
- Outside SHIFT: ser_valid, ser_first, ser_last and ser_bit are 0. ser_bit is gated by ser_valid.
- The final shift of a frame leaves the shift register at 0. No extra clear is issued.
- No backpressure on the serial side. Once loaded, a frame always completes unless rst asserts.

## Timing
- Reset values
  - in_ready=1.
  - sr_load, sr_shift, sr_data_in, ser_valid, ser_bit, ser_first, ser_last, busy = 0.
  - word_count=0; FSM=IDLE; FIFO empty.
- Reset mid-operation
  - Asynchronous clear of the FSM, FIFO and counters; any partial frame is abandoned.
  - The shift register shares rst, so both blocks restart consistent.
- Latency
  - A word pushed at edge N into an empty, IDLE block gives LOAD in cycle N+1.
  - Bit 0 appears in cycle N+2; bit WIDTH-1 in cycle N+1+WIDTH.
- Frame period for back-to-back words: 1 + WIDTH + GAP cycles (6 for the defaults).
- ser_bit samples sr_msb in the same cycle (combinational path gated by state).
- The shift register must have a single-cycle load/shift response.
- All other outputs are registered or state-decoded.

## Test plan
- Single word: in_data=4'b1011 -> LOAD one cycle later with sr_data_in=1011; ser_bit=1,0,1,1 over the next 4 cycles; ser_first on the first, ser_last on the fourth; word_count=1; busy low after the frame.
- Back-to-back, GAP=1: push 0xA, 0x5, 0xF -> frames start every 6 cycles; bits 1010, 0101, 1111; exactly one idle cycle between frames; word_count=3.
- FIFO full, DEPTH=2: hold in_valid for 4 words while the first frame runs -> in_ready drops when 2 entries are buffered; no word is lost or duplicated; output order matches input order.
- GAP=0: two queued words 0x9 and 0x6 -> LOAD immediately follows ser_last; bits 1001 then 0110.
- Reset mid-frame: assert rst after bit 1 of 0xC with one word queued -> all outputs 0 at once; no further ser_valid; in_ready=1; word_count=0.
- Wrap: run 256 frames of 0x3 -> word_count returns to 0; bits are 0011 in every frame.
